// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bit_serializer_pkg                                                         |
// | Shared state encodings, gap-counter width and helpers for bit_serializer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bit_serializer_pkg;

  localparam int GAP_W = 4;

  // 2'b11 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } ser_state_t;

  // Gap counter counts down to zero, so a gap of N idle cycles starts at N-1.
  function automatic logic [GAP_W-1:0] gap_init(input int gap);
    if (gap > 0) begin
      return GAP_W'(gap - 1);
    end
    return '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ser_hold_buf                                                               |
// | One-entry holding register with full flag and load/unload strobes.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // A load can only be requested while empty, so it never collides with an unload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (load) begin
        r_full <= 1'b1;
        r_data <= din;
      end else if (unload) begin
        r_full <= 1'b0;
      end
    end
  end

  assign dout = r_data;
  assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bit_serializer                                                             |
// | Parallel-to-serial front end: valid/ready words out MSB-first on x.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
  localparam logic [GAP_W-1:0]   c_gap_init = gap_init(GAP);

  ser_state_t         r_state;
  ser_state_t         w_state_nx;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   w_shreg_nx;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [c_cnt_w-1:0] w_bit_cnt_nx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_cnt_nx;

  logic               w_xfer;
  logic               w_word_end;
  logic               w_hold_load;
  logic               w_hold_unload;
  logic               w_hold_full;
  logic [WIDTH-1:0]   w_hold_data;

  assign w_xfer = din_valid && !w_hold_full;

  ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .load   (w_hold_load),
    .unload (w_hold_unload),
    .din    (din),
    .dout   (w_hold_data),
    .full   (w_hold_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_shreg   <= w_shreg_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_gap_cnt <= w_gap_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shreg_nx    = r_shreg;
    w_bit_cnt_nx  = r_bit_cnt;
    w_gap_cnt_nx  = r_gap_cnt;
    w_hold_load   = 1'b0;
    w_hold_unload = 1'b0;
    w_word_end    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nx   = S_SHIFT;
          w_shreg_nx   = din;
          w_bit_cnt_nx = c_last_bit;
        end
      end

      S_SHIFT: begin
        w_shreg_nx   = {r_shreg[WIDTH-2:0], 1'b0};
        w_bit_cnt_nx = r_bit_cnt - c_cnt_w'(1);
        if (r_bit_cnt == '0) begin
          if (GAP > 0) begin
            // A word offered on the last bit still has to wait out the gap.
            w_state_nx   = S_GAP;
            w_gap_cnt_nx = c_gap_init;
            w_hold_load  = w_xfer;
          end else begin
            w_word_end = 1'b1;
          end
        end else begin
          w_hold_load = w_xfer;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_word_end = 1'b1;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
          w_hold_load  = w_xfer;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Word boundary: the held word has priority, then a word arriving on this edge.
    if (w_word_end) begin
      if (w_hold_full) begin
        w_state_nx    = S_SHIFT;
        w_shreg_nx    = w_hold_data;
        w_bit_cnt_nx  = c_last_bit;
        w_hold_unload = 1'b1;
      end else if (w_xfer) begin
        w_state_nx   = S_SHIFT;
        w_shreg_nx   = din;
        w_bit_cnt_nx = c_last_bit;
      end else begin
        w_state_nx = S_IDLE;
      end
    end
  end

  assign din_ready = !w_hold_full;
  assign x_valid   = (r_state == S_SHIFT);
  assign x         = x_valid ? r_shreg[WIDTH-1] : IDLE_LEVEL;
  assign word_done = x_valid && (r_bit_cnt == '0);
  assign busy      = (r_state != S_IDLE) || w_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bit_serializer                                                          |
// | Randomized bench for bit_serializer against a word-queue reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din0  = '0;
  logic [W-1:0] din2  = '0;
  logic         dv0   = 1'b0;
  logic         dv2   = 1'b0;
  logic         rdy0, x0, xv0, wd0, busy0;
  logic         rdy2, x2, xv2, wd2, busy2;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .din(din0), .din_valid(dv0), .din_ready(rdy0),
    .x(x0), .x_valid(xv0), .word_done(wd0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(W), .GAP(2), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .din(din2), .din_valid(dv2), .din_ready(rdy2),
    .x(x2), .x_valid(xv2), .word_done(wd2), .busy(busy2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted words wait in mq; m_cur is being shifted out.
  int           sel        = 0;
  int           m_gap      = 0;
  logic         m_idle     = 1'b0;
  logic [W-1:0] mq[$];
  logic [W-1:0] m_cur      = '0;
  int           m_bits     = 0;
  int           m_gap_left = 0;
  bit           last_acc   = 1'b0;

  logic         o_x, o_xv, o_wd, o_rdy, o_busy;
  logic [31:0]  cap  = '0;
  int           ncap = 0;
  int           nwd  = 0;
  int           cyc  = 0;
  int           first_xv = -1;
  int           last_xv  = -1;
  logic [W-1:0] tx[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cur      = '0;
    m_bits     = 0;
    m_gap_left = 0;
  endtask

  task automatic compare_outputs(input string tag);
    logic e_xv;
    if (sel == 0) {o_x, o_xv, o_wd, o_rdy, o_busy} = {x0, xv0, wd0, rdy0, busy0};
    else          {o_x, o_xv, o_wd, o_rdy, o_busy} = {x2, xv2, wd2, rdy2, busy2};
    e_xv = (m_bits > 0);
    chk({tag, "_x_valid"},   32'(o_xv),   32'(e_xv));
    chk({tag, "_x"},         32'(o_x),    32'(e_xv ? m_cur[m_bits-1] : m_idle));
    chk({tag, "_word_done"}, 32'(o_wd),   32'(m_bits == 1));
    chk({tag, "_din_ready"}, 32'(o_rdy),  32'(mq.size() == 0));
    chk({tag, "_busy"},      32'(o_busy), 32'(m_bits > 0 || m_gap_left > 0 || mq.size() > 0));
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    if (sel == 0) begin dv0 = v; din0 = d; end
    else          begin dv2 = v; din2 = d; end
    @(posedge clk);
    last_acc = v && (mq.size() == 0);
    if (last_acc) mq.push_back(d);
    if (m_bits > 0) begin
      m_bits--;
      if (m_bits == 0) m_gap_left = m_gap;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end
    if (m_bits == 0 && m_gap_left == 0 && mq.size() > 0) begin
      m_cur  = mq.pop_front();
      m_bits = W;
    end
    @(negedge clk);
    cyc++;
    compare_outputs("cyc");
    if (o_xv) begin
      cap = {cap[30:0], o_x};
      ncap++;
      if (first_xv < 0) first_xv = cyc;
      last_xv = cyc;
    end
    if (o_wd) nwd++;
  endtask

  // Source holds din and valid until the word is taken.
  task automatic run_tx(input bit rnd_valid);
    logic [W-1:0] cur;
    bit           offering;
    int           guard;
    cur      = '0;
    offering = 1'b0;
    guard    = 0;
    while ((tx.size() > 0 || offering) && guard < 2000) begin
      if (!offering && tx.size() > 0 && (!rnd_valid || $urandom_range(0, 2) != 0)) begin
        cur      = tx.pop_front();
        offering = 1'b1;
      end
      step(offering, offering ? cur : W'($urandom));
      if (last_acc) offering = 1'b0;
      guard++;
    end
    if (guard >= 2000) chk("tx_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_bits > 0 || m_gap_left > 0 || mq.size() > 0) && guard < 200) begin
      step(1'b0, W'($urandom));
      guard++;
    end
    step(1'b0, '0);
    if (guard >= 200) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_capture();
    cap      = '0;
    ncap     = 0;
    nwd      = 0;
    first_xv = -1;
    last_xv  = -1;
  endtask

  initial begin
    #1;
    model_clear();
    sel = 0; compare_outputs("reset0");
    sel = 1; m_idle = 1'b1; compare_outputs("reset2");
    sel = 0; m_idle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // single word
    start_capture();
    tx.push_back(8'hB5);
    run_tx(1'b0);
    drain();
    chk("b5_bits", cap[7:0], 32'h000000B5);
    chk("b5_nbits", 32'(ncap), 32'd8);
    chk("b5_word_done", 32'(nwd), 32'd1);

    // back-to-back, gapless
    start_capture();
    tx.push_back(8'hA5); tx.push_back(8'h3C);
    run_tx(1'b0);
    drain();
    chk("b2b_bits", {16'h0, cap[15:0]}, 32'h0000A53C);
    chk("b2b_span", 32'(last_xv - first_xv + 1), 32'd16);
    chk("b2b_word_done", 32'(nwd), 32'd2);

    // backpressure, three words
    start_capture();
    tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
    run_tx(1'b0);
    drain();
    chk("bp_bits", {8'h0, cap[23:0]}, 32'h00112233);
    chk("bp_span", 32'(last_xv - first_xv + 1), 32'd24);

    // asynchronous reset mid-word with hold occupied
    step(1'b1, 8'hC3);
    step(1'b1, 8'h5A);
    step(1'b0, 8'h00);
    chk("rst_hold_full", 32'(rdy0), 32'd0);
    #2 reset = 1'b0;
    #1;
    model_clear();
    compare_outputs("rst_async");
    @(negedge clk);
    reset = 1'b1;
    start_capture();
    tx.push_back(8'h81);
    run_tx(1'b0);
    drain();
    chk("rst_81_bits", cap[7:0], 32'h00000081);
    chk("rst_81_nbits", 32'(ncap), 32'd8);

    // detector stimulus pattern
    start_capture();
    tx.push_back(8'b01110110);
    run_tx(1'b0);
    drain();
    chk("pat_bits", cap[7:0], 32'h00000076);

    // random traffic, GAP=0
    for (int i = 0; i < 40; i++) tx.push_back(W'($urandom));
    run_tx(1'b1);
    drain();

    // GAP=2 instance, IDLE_LEVEL=1
    sel = 1; m_gap = 2; m_idle = 1'b1;
    model_clear();
    start_capture();
    tx.push_back(8'hFF); tx.push_back(8'h01);
    run_tx(1'b0);
    drain();
    chk("gap_bits", {16'h0, cap[15:0]}, 32'h0000FF01);
    chk("gap_word_done", 32'(nwd), 32'd2);
    chk("gap_span", 32'(last_xv - first_xv + 1), 32'd18);

    for (int i = 0; i < 30; i++) tx.push_back(W'($urandom));
    run_tx(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
